// File: rtl/timer_ctrl_pkg.sv
// timer_ctrl_pkg: shared state encoding and parameter defaults for timer_ctrl_fsm.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package timer_ctrl_pkg;

  // Encoded values are visible on state_dbg, so keep them fixed.
  typedef enum logic [2:0] {
    SEARCH = 3'd0,
    SHIFT  = 3'd1,
    COUNT  = 3'd2,
    DONE   = 3'd3
  } ctrl_state_t;

  localparam int                   DEF_PAT_W        = 4;
  localparam logic [DEF_PAT_W-1:0] DEF_PATTERN      = 4'b1101;
  localparam int                   DEF_SHIFT_CYCLES = 4;

endpackage

// File: rtl/timer_ctrl_fsm_if.sv
// timer_ctrl_fsm_if: bit stream, datapath handshake and status bundle of the timer controller.
// Latency: n/a (wires only).
// Backpressure: none; done is held until ack, done_counting is a level from the datapath.
// Ports: slave = controller (consumes data/done_counting/ack, drives enables/status),
//        master = surrounding logic (the mirror image).
// Optional: TIMER_CTRL_HITCNT_EN adds hit_count (8-bit saturating match counter).
interface timer_ctrl_fsm_if;
  logic       data;
  logic       done_counting;
  logic       ack;
  logic       shift_ena;
  logic       count_ena;
  logic       done;
  logic [2:0] state_dbg;
`ifdef TIMER_CTRL_HITCNT_EN
  logic [7:0] hit_count;
`endif

  modport slave (
    input  data, done_counting, ack,
    output shift_ena, count_ena, done, state_dbg
`ifdef TIMER_CTRL_HITCNT_EN
    , output hit_count
`endif
  );

  modport master (
    output data, done_counting, ack,
    input  shift_ena, count_ena, done, state_dbg
`ifdef TIMER_CTRL_HITCNT_EN
    , input hit_count
`endif
  );
endinterface

// File: rtl/pattern_match_sr.sv
// pattern_match_sr: serial start-pattern detector (history shift register + fill count).
// Latency: match is combinational on the current data bit and the registered history.
// Backpressure: none; history only advances while enable is high, clear has priority.
// Ports: clk, reset_n (async, active low), enable (shift this bit), clear (forget history),
//        data (serial bit, MSB of pattern first), match (pattern completes with this bit).
module pattern_match_sr
  import timer_ctrl_pkg::*;
#(
  parameter int             PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic clear,
  input  logic data,
  output logic match
);

  localparam int FW = $clog2(PAT_W);
  localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W - 1);

  logic [PAT_W-2:0] hist_q;
  logic [FW-1:0]    fill_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (clear) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (enable) begin
      hist_q <= {hist_q, data};
      // Saturate: once the window is full it stays full.
      if (fill_q != FILL_MAX) begin
        fill_q <= fill_q + FW'(1);
      end
    end
  end

  // The fill count stops the reset-zeroed history from completing a pattern early.
  assign match = enable && (fill_q == FILL_MAX) && ({hist_q, data} == PATTERN);

endmodule

// File: rtl/timer_ctrl_fsm.sv
// timer_ctrl_fsm: start-pattern search, then SHIFT_CYCLES of shift_ena, count_ena until done_counting, done until ack.
// Latency: shift_ena rises the cycle after the matching bit; all outputs are Moore (registered state only).
// Backpressure: done holds until ack; done_counting and ack are ignored outside COUNT and DONE.
// Ports: clk, reset_n (async active low), bus (slave modport: data, done_counting, ack in;
//        shift_ena, count_ena, done, state_dbg out).
// Optional: define TIMER_CTRL_HITCNT_EN for bus.hit_count, an 8-bit saturating count of matches.
module timer_ctrl_fsm
  import timer_ctrl_pkg::*;
#(
  parameter int               PAT_W        = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN      = DEF_PATTERN,
  parameter int               SHIFT_CYCLES = DEF_SHIFT_CYCLES
) (
  input  logic            clk,
  input  logic            reset_n,
  timer_ctrl_fsm_if.slave bus
);

  localparam int SC_W = $clog2(SHIFT_CYCLES + 1);

  ctrl_state_t     state_q, state_d;
  logic [SC_W-1:0] shift_cnt_q, shift_cnt_d;
  logic            match;
  logic            search_en;
  logic            clear_hist;

  pattern_match_sr #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN)
  ) u_match (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (search_en),
    .clear   (clear_hist),
    .data    (bus.data),
    .match   (match)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= SEARCH;
      shift_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      shift_cnt_q <= shift_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_cnt_d = shift_cnt_q;
    search_en   = 1'b0;
    clear_hist  = 1'b0;
    case (state_q)
      SEARCH: begin
        search_en = 1'b1;
        if (match) begin
          state_d     = SHIFT;
          // Counts down to 0 inclusive, giving SHIFT_CYCLES cycles in SHIFT.
          shift_cnt_d = SC_W'(SHIFT_CYCLES - 1);
        end
      end
      SHIFT: begin
        if (shift_cnt_q == '0) begin
          state_d = COUNT;
        end else begin
          shift_cnt_d = shift_cnt_q - SC_W'(1);
        end
      end
      COUNT: begin
        if (bus.done_counting) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.ack) begin
          state_d    = SEARCH;
          // Bits seen before the ack must never contribute to the next match.
          clear_hist = 1'b1;
        end
      end
      default: begin
        state_d     = SEARCH;
        shift_cnt_d = '0;
        clear_hist  = 1'b1;
      end
    endcase
  end

  assign bus.shift_ena = (state_q == SHIFT);
  assign bus.count_ena = (state_q == COUNT);
  assign bus.done      = (state_q == DONE);
  assign bus.state_dbg = state_q;

`ifdef TIMER_CTRL_HITCNT_EN
  logic [7:0] hit_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_cnt_q <= '0;
    end else if ((state_q == SEARCH) && match && (hit_cnt_q != 8'hFF)) begin
      hit_cnt_q <= hit_cnt_q + 8'd1;
    end
  end

  assign bus.hit_count = hit_cnt_q;
`endif

endmodule

// File: tb/tb_timer_ctrl_fsm.sv
// tb_timer_ctrl_fsm: directed vector table for timer_ctrl_fsm plus reset and hit-count sequences.
// Latency: inputs change on the falling edge, outputs are compared 1 time unit after the rising edge.
// Backpressure: n/a.
module tb_timer_ctrl_fsm;

  logic clk;
  logic reset_n;

  timer_ctrl_fsm_if bus ();

  timer_ctrl_fsm dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [2:0] S_SE = 3'd0;
  localparam logic [2:0] S_SH = 3'd1;
  localparam logic [2:0] S_CO = 3'd2;
  localparam logic [2:0] S_DN = 3'd3;

  typedef struct {
    logic       d;
    logic       dc;
    logic       ak;
    logic       rst;   // pull reset_n low just before this vector's edge
    logic [2:0] es;    // expected state after the edge
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  function automatic void add(logic d, logic dc, logic ak, logic rst, logic [2:0] es);
    vec_t v;
    v.d = d; v.dc = dc; v.ak = ak; v.rst = rst; v.es = es;
    vecs.push_back(v);
  endfunction

  function automatic logic [5:0] expect_of(logic [2:0] es);
    return {es, es == S_SH, es == S_CO, es == S_DN};
  endfunction

  function automatic logic [5:0] observed();
    return {bus.state_dbg, bus.shift_ena, bus.count_ena, bus.done};
  endfunction

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b", name, act, exp);
    end
  endtask

  task automatic edge_in(logic d, logic dc, logic ak);
    @(negedge clk);
    bus.data = d; bus.done_counting = dc; bus.ack = ak;
    @(posedge clk);
    #1;
  endtask

`ifdef TIMER_CTRL_HITCNT_EN
  task automatic full_run();
    edge_in(1, 0, 0); edge_in(1, 0, 0); edge_in(0, 0, 0); edge_in(1, 0, 0);
    for (int k = 0; k < 4; k++) edge_in(0, 0, 0);
    edge_in(0, 1, 0);
    edge_in(0, 0, 1);
  endtask
`endif

  initial begin
    // Run 1: 1101 with done_counting/ack held high through SEARCH and SHIFT (must be ignored).
    add(1,1,1,0,S_SE); add(1,1,1,0,S_SE); add(0,1,1,0,S_SE); add(1,1,1,0,S_SH);
    add(1,1,1,0,S_SH); add(0,1,1,0,S_SH); add(0,1,1,0,S_SH); add(0,1,1,0,S_CO);
    add(0,1,0,0,S_DN);                          // one cycle in COUNT even with done_counting high
    for (int k = 0; k < 5; k++) add(1,1,0,0,S_DN);
    add(1,0,1,0,S_SE);                          // ack
    // Fresh bits only: 1,0,1 must not match; 1,0,1,1,0,1 matches on the last bit.
    add(1,0,0,0,S_SE); add(0,0,0,0,S_SE); add(1,0,0,0,S_SE);
    add(1,0,0,0,S_SE); add(0,0,0,0,S_SE); add(1,0,0,0,S_SH);
    for (int k = 0; k < 3; k++) add(0,0,0,0,S_SH);
    for (int k = 0; k < 11; k++) add(0,0,0,0,S_CO);  // done_counting low for 10 cycles in COUNT
    add(0,1,0,0,S_DN);
    for (int k = 0; k < 5; k++) add(0,0,0,0,S_DN);
    add(0,0,1,0,S_SE);
    // Overlap: 1,1,1,0,1 matches on the 5th bit.
    add(1,0,0,0,S_SE); add(1,0,0,0,S_SE); add(1,0,0,0,S_SE); add(0,0,0,0,S_SE);
    add(1,0,0,0,S_SH);
    for (int k = 0; k < 3; k++) add(0,0,0,0,S_SH);
    add(0,0,0,0,S_CO); add(0,1,0,0,S_DN); add(0,0,1,0,S_SE);
    // Reset on the second SHIFT cycle, then a full fresh pattern is required.
    add(1,0,0,0,S_SE); add(1,0,0,0,S_SE); add(0,0,0,0,S_SE); add(1,0,0,0,S_SH);
    add(0,0,0,0,S_SH); add(0,0,0,1,S_SE);
    add(1,0,0,0,S_SE); add(0,0,0,0,S_SE); add(1,0,0,0,S_SE);
    add(1,0,0,0,S_SE); add(0,0,0,0,S_SE); add(1,0,0,0,S_SH);
    for (int k = 0; k < 3; k++) add(0,0,0,0,S_SH);
    add(0,0,0,0,S_CO); add(0,1,0,0,S_DN); add(0,0,1,0,S_SE);

    // Reset held: everything low, state SEARCH.
    reset_n = 1'b0;
    bus.data = 1'b1; bus.done_counting = 1'b1; bus.ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", {2'b00, observed()}, {2'b00, expect_of(S_SE)});

    foreach (vecs[i]) begin
      @(negedge clk);
      reset_n = 1'b1;
      bus.data = vecs[i].d; bus.done_counting = vecs[i].dc; bus.ack = vecs[i].ak;
      if (vecs[i].rst) begin
        reset_n = 1'b0;
        #1;
        check($sformatf("async_rst_vec%0d", i), {2'b00, observed()}, {2'b00, expect_of(S_SE)});
      end
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), {2'b00, observed()}, {2'b00, expect_of(vecs[i].es)});
    end

`ifdef TIMER_CTRL_HITCNT_EN
    // Only the pattern after the mid-SHIFT reset counts since that reset.
    check("hit_after_table", bus.hit_count, 8'd1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("hit_reset", bus.hit_count, 8'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int r = 0; r < 3; r++) full_run();
    check("hit_3", bus.hit_count, 8'd3);
    for (int r = 0; r < 297; r++) full_run();
    check("hit_sat", bus.hit_count, 8'd255);
    check("hit_state", {5'b0, bus.state_dbg}, {5'b0, S_SE});
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
